// File: rtl/inv_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// inv_arbiter_pkg
// Shared definitions for the round-robin inverter arbiter:
//   - DEFAULT_N_REQ / DEFAULT_WIDTH : default requester count and operand width
//   - state_t                       : arbiter FSM state encoding (IDLE, RESP)
// ---------------------------------------------------------------------------
package inv_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,    // waiting to accept an operand
        RESP = 1'b1     // holding a result until the consumer takes it
    } state_t;

endpackage

// File: rtl/inv_arbiter_inv.sv
// ---------------------------------------------------------------------------
// inv_arbiter_inv
// Purely combinational WIDTH-bit bitwise inverter.
// Ports:
//   din  : operand
//   dout : bitwise NOT of din
// ---------------------------------------------------------------------------
module inv_arbiter_inv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = ~din;

endmodule

// File: rtl/inv_arbiter.sv
// ---------------------------------------------------------------------------
// inv_arbiter
// Shares one inverter among N_REQ requesters. A round-robin selector picks the
// first valid requester at or above rr_ptr (wrapping), the selected operand is
// inverted and held in a one-deep response register until the consumer takes
// it. One result every two cycles at best.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   req_valid  : per-requester operand valid            [N_REQ]
//   req_data   : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot grant, operand taken on valid & ready
//   rsp_valid  : result available
//   rsp_ready  : consumer accepts result
//   rsp_data   : bitwise inverse of the accepted operand
//   rsp_id     : index of the requester that owns rsp_data
//   done_count : completed response handshakes, wraps 255 -> 0
// ---------------------------------------------------------------------------
module inv_arbiter
    import inv_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEFAULT_N_REQ,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic [7:0]             done_count
);

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic [ID_W-1:0]  rsp_id_reg, rsp_id_next;
    logic [7:0]       done_count_reg, done_count_next;

    // Unpack operands so the selected one can be picked by index.
    logic [WIDTH-1:0] operand [N_REQ];
    logic [N_REQ-1:0] grant_vec;

    logic             sel_found;
    logic [ID_W-1:0]  sel_idx;
    logic [ID_W:0]    cand;        // one extra bit so rr_ptr + k cannot overflow
    logic [WIDTH-1:0] sel_operand;
    logic [WIDTH-1:0] inv_result;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign operand[gi]   = req_data[gi*WIDTH +: WIDTH];
            assign grant_vec[gi] = sel_found && (sel_idx == ID_W'(gi));
        end
    endgenerate

    // Round-robin search. Walking the offsets from farthest to nearest and
    // overwriting on every hit leaves the nearest valid requester selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign sel_operand = operand[sel_idx];

    inv_arbiter_inv #(
        .WIDTH (WIDTH)
    ) u_inv (
        .din  (sel_operand),
        .dout (inv_result)
    );

    // Next-state logic. In IDLE any selected requester is accepted; in RESP
    // requests are ignored and only the response handshake moves the FSM on.
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_id_next     = rsp_id_reg;
        done_count_next = done_count_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    rsp_data_next = inv_result;
                    rsp_id_next   = sel_idx;
                    state_next    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next      = IDLE;
                    rr_ptr_next     = (rsp_id_reg == ID_W'(N_REQ - 1)) ? '0
                                                                        : rsp_id_reg + ID_W'(1);
                    done_count_next = done_count_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            rsp_data_reg   <= '0;
            rsp_id_reg     <= '0;
            done_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_id_reg     <= rsp_id_next;
            done_count_reg <= done_count_next;
        end
    end

    // Grants are suppressed while reset is held so nothing can be accepted
    // in the same instant the state is being cleared.
    assign req_ready  = (state_reg == IDLE && !reset) ? grant_vec : '0;
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_data   = rsp_data_reg;
    assign rsp_id     = rsp_id_reg;
    assign done_count = done_count_reg;

endmodule

// File: tb/tb_inv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inv_arbiter
// Self-checking bench for inv_arbiter (N_REQ=4, WIDTH=4). Expected responses
// are pushed to a scoreboard queue when stimulus is driven and popped when the
// DUT presents a result being handshaked.
// ---------------------------------------------------------------------------
module tb_inv_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [7:0]  done_count;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    inv_arbiter #(
        .N_REQ (4),
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 4'hF; req_data = 16'h1234; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, done_count, req_ready} !== 19'h0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h id=%0d cnt=%0d rdy=%b expected all zero",
                     rsp_valid, rsp_data, rsp_id, done_count, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold: got v=%b rdy=%b expected 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b0; req_valid = '0; req_data = '0;
        $display("test_reset: done");
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0001; req_data = 16'h0000; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        exp_q.push_back('{id: 2'd0, data: 4'hF});
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid);
        end
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL single_sb_empty: got empty queue expected entry");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                failures++;
                $display("FAIL single_rsp: got id=%0d d=%h expected id=%0d d=%h", rsp_id, rsp_data, e.id, e.data);
            end
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, done_count} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL single_done: got v=%b cnt=%0d expected v=0 cnt=1", rsp_valid, done_count);
        end
        $display("test_single: id=%0d data=%h count=%0d", rsp_id, rsp_data, done_count);
    endtask

    task automatic test_rotation();
        int got  = 0;
        int last = -1;
        do_reset();
        req_data = 16'hC953; req_valid = 4'hF; rsp_ready = 1'b1;
        exp_q.push_back('{id: 2'd0, data: 4'hC});
        exp_q.push_back('{id: 2'd1, data: 4'hA});
        exp_q.push_back('{id: 2'd2, data: 4'h6});
        exp_q.push_back('{id: 2'd3, data: 4'h3});
        exp_q.push_back('{id: 2'd0, data: 4'hC});
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                    failures++;
                    $display("FAIL rotation_rsp%0d: got id=%0d d=%h expected id=%0d d=%h",
                             got, rsp_id, rsp_data, e.id, e.data);
                end
                $display("test_rotation: rsp id=%0d data=%h", rsp_id, rsp_data);
                got++;
                last = cyc;
                if (got == 5) req_valid = '0;
            end
        end
        checks++;
        if (got != 5 || last != 8) begin
            failures++;
            $display("FAIL rotation_rate: got %0d responses last at cycle %0d expected 5 at cycle 8", got, last);
        end
        @(negedge clk);
        checks++;
        if (done_count !== 8'd5) begin
            failures++;
            $display("FAIL rotation_done: got %0d expected 5", done_count);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 4'b0100; req_data = 16'h0700; rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_grant: got %b expected 0100", req_ready);
        end
        exp_q.push_back('{id: 2'd2, data: 4'h8});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'hF; rsp_ready = (i == 2) ? 1'b0 : 1'b0;
            #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, 4'h8, 2'd2, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b expected v=1 d=8 id=2 rdy=0000",
                         i, rsp_valid, rsp_data, rsp_id, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = '0;
        #1;
        if (!rsp_valid || exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL bp_release: got v=%b q=%0d expected v=1 q=1", rsp_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                failures++;
                $display("FAIL bp_rsp: got id=%0d d=%h expected id=%0d d=%h", rsp_id, rsp_data, e.id, e.data);
            end
        end
        // rsp_ready stays high through idle cycles; nothing must be counted.
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, done_count} !== {1'b0, 8'd6}) begin
                failures++;
                $display("FAIL bp_idle_ready: got v=%b cnt=%0d expected v=0 cnt=6", rsp_valid, done_count);
            end
        end
        $display("test_backpressure: count=%0d", done_count);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_data = 16'h0050; rsp_ready = 1'b0;
        exp_q.push_back('{id: 2'd1, data: 4'hA});
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: got v=%b expected 1", rsp_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, done_count, req_ready} !== 13'h0) begin
            failures++;
            $display("FAIL areset_clear: got v=%b cnt=%0d rdy=%b expected 0/0/0000", rsp_valid, done_count, req_ready);
        end
        void'(exp_q.pop_front());   // pending result is dropped by reset
        #1;
        reset = 1'b0; req_valid = 4'b1010; req_data = 16'h3050; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL areset_grant: got %b expected 0010", req_ready);
        end
        exp_q.push_back('{id: 2'd1, data: 4'hA});
        @(negedge clk);
        req_valid = '0;
        if (!rsp_valid || exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL areset_rsp_missing: got v=%b q=%0d expected v=1 q=1", rsp_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                failures++;
                $display("FAIL areset_rsp: got id=%0d d=%h expected id=%0d d=%h", rsp_id, rsp_data, e.id, e.data);
            end
        end
        @(negedge clk);
        checks++;
        if (done_count !== 8'd1) begin
            failures++;
            $display("FAIL areset_done: got %0d expected 1", done_count);
        end
        $display("test_async_reset: count=%0d", done_count);
    endtask

    task automatic test_sweep();
        int v   = 0;
        int got = 0;
        do_reset();
        req_valid = 4'b0010; req_data = '0; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
            #1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sweep_sb_empty: got empty queue expected entry");
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                        failures++;
                        $display("FAIL sweep_op%0d: got id=%0d d=%h expected id=%0d d=%h",
                                 v, rsp_id, rsp_data, e.id, e.data);
                    end
                end
                $display("test_sweep: op=%h rsp=%h", 4'(v), rsp_data);
                got++;
                v++;
                req_data[7:4] = 4'(v);
                if (got == 16) req_valid = '0;
            end else if (req_ready == 4'b0010) begin
                exp_q.push_back('{id: 2'd1, data: 4'(15 - v)});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({rsp_valid, done_count} !== {1'b0, 8'd16} || got != 16) begin
            failures++;
            $display("FAIL sweep_done: got v=%b cnt=%0d n=%0d expected v=0 cnt=16 n=16", rsp_valid, done_count, got);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b1000; req_data = 16'h6000; rsp_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            #1;
            checks++;
            if (req_ready !== 4'b1000) begin
                failures++;
                $display("FAIL wrap_grant%0d: got %b expected 1000", pass, req_ready);
            end
            exp_q.push_back('{id: 2'd3, data: 4'h9});
            @(negedge clk);
            if (pass == 1) req_valid = '0;
            if (!rsp_valid || exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wrap_rsp_missing%0d: got v=%b q=%0d expected v=1 q=1", pass, rsp_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                checks++;
                if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                    failures++;
                    $display("FAIL wrap_rsp%0d: got id=%0d d=%h expected id=%0d d=%h",
                             pass, rsp_id, rsp_data, e.id, e.data);
                end
            end
            $display("test_wrap: pass %0d id=%0d data=%h", pass, rsp_id, rsp_data);
            @(negedge clk);
        end
        checks++;
        if (done_count !== 8'd2) begin
            failures++;
            $display("FAIL wrap_done: got %0d expected 2", done_count);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_async_reset();
        test_sweep();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_arbiter.md
INV_ARBITER -- requirements
Module: inv_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the inverter; legal range 2..8.
REQ-002 Parameter WIDTH, default 4: operand/result width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester operand valid.
REQ-006 req_data  input  N_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  output  N_REQ  one-hot grant/accept; operand i is taken when req_valid[i] and req_ready[i] are both 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_data  output  WIDTH  bitwise inverse of the accepted operand.
REQ-011 rsp_id  output  $clog2(N_REQ)  index of the requester that owns rsp_data.
REQ-012 done_count  output  8  count of completed response handshakes, wraps 255->0.

Function
REQ-013 The FSM SHALL have two states: IDLE and RESP.
REQ-014 In IDLE, req_ready SHALL be the one-hot selection of the first asserted req_valid bit, searching from rr_ptr upward modulo N_REQ; req_ready SHALL be all-zero when no req_valid bit is set or the state is RESP.
REQ-015 On an accepting edge in IDLE, the block SHALL register ~req_data[sel], rsp_id <= sel, and state <= RESP, so rsp_valid rises exactly 1 cycle after acceptance.
REQ-016 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL stay stable until rsp_ready is 1.
REQ-017 On rsp_valid and rsp_ready: state <= IDLE, rr_ptr <= (rsp_id+1) mod N_REQ, done_count <= done_count+1.
REQ-018 Next acceptance SHALL occur no earlier than the cycle after the response handshake; peak throughput is 1 result per 2 cycles.
REQ-019 rsp_data SHALL equal the bitwise NOT of the operand (for example, 4'h0 gives 4'hF and 4'hA gives 4'h5), with no arithmetic offset.
REQ-020 req_valid changes during RESP SHALL have no effect; a requester that deasserts before acceptance is simply not served.
REQ-021 With all requesters continuously valid, grants SHALL rotate 0,1,..,N_REQ-1,0.. with no requester skipped.
REQ-022 rsp_ready asserted in IDLE SHALL be ignored.

Reset
REQ-023 While reset is high, regardless of clk: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, done_count=0, req_ready=0.
REQ-024 Reset asserted during RESP SHALL drop the pending result with no handshake; done_count is not incremented.
REQ-025 After reset deasserts, the first grant SHALL go to the lowest-indexed valid requester.

Structure
REQ-026 Package inv_arbiter_pkg SHALL hold the state enum typedef (IDLE, RESP) and the default WIDTH/N_REQ constants.
REQ-027 The inversion SHALL be performed by one instance of the team's existing inv sub-module (WIDTH-bit) on the selected operand; the block contains no other inverter.
REQ-028 The round-robin selector SHALL be a function or always_comb block inside inv_arbiter, not a separate module.

Verification
REQ-029 Reset, then req_valid=4'b0001, req_data[3:0]=4'h0, rsp_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle rsp_valid=1, rsp_data=4'hF, rsp_id=0; done_count=1 afterwards.
REQ-030 All four valid with operands 3,5,9,C, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 and rsp_data F-operand each time (C,A,6,3).
REQ-031 rsp_ready held 0 for 5 cycles after a requester-2 operand of 4'h7 -> rsp_valid stays 1, rsp_data=4'h8, rsp_id=2 stable, req_ready=0 throughout.
REQ-032 Reset pulsed mid-RESP (asynchronously, between edges) -> rsp_valid=0 immediately, done_count=0, next grant goes to the lowest valid index.
REQ-033 Sweep all 16 operands from requester 1 -> rsp_data = 15-operand for every value; done_count=16.
REQ-034 Only requester 3 valid after serving requester 3 (rr_ptr=0) -> wrap search grants 3 again in the next IDLE cycle.
